l2_frame_ctrl: RTL and testbench

Frame sequencer for the layer-2 convolution datapath. Accepts a frame-start command, issues one `strt` pulse per output position when the upstream feature source has a position burst ready and the layer is idle, and counts words drained by the downstream layer. When all positions are computed and all output words consumed, it pulses `tx_done` to rewind the layer's address counters and state machines for the next image. It also provides abort and drain-timeout recovery.

---
 rtl/l2_frame_ctrl_if.sv | 53 +++++
 rtl/l2_frame_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_l2_frame_ctrl.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// l2_frame_ctrl_if
//
// Purpose:
//   Bundles the handshake and status signals of the layer-2 frame sequencer.
//   The controller connects through the slave modport. The environment that
//   drives it (host, feature source, layer and downstream reader) uses the
//   master modport.
//
// Signals (direction seen from the controller):
//   frame_go     in   1-cycle frame start command
//   abort        in   level, terminates the current frame
//   src_rdy      in   upstream holds a full position burst
//   src_go       out  1-cycle pulse, upstream starts its burst next cycle
//   strt         out  1-cycle pulse to the layer, coincident with src_go
//   bsy_in       in   layer busy
//   out_ack      in   downstream consumed one output word this cycle
//   tx_done      out  1-cycle pulse that rewinds the layer for the next image
//   frame_active out  frame in progress
//   frame_done   out  1-cycle pulse on successful completion
//   err_tmo      out  sticky drain-timeout flag
//   pos_cnt      out  positions issued this frame
//   out_cnt      out  words acknowledged this frame
// ---------------------------------------------------------------------------
interface l2_frame_ctrl_if;
    logic       frame_go;
    logic       abort;
    logic       src_rdy;
    logic       src_go;
    logic       strt;
    logic       bsy_in;
    logic       out_ack;
    logic       tx_done;
    logic       frame_active;
    logic       frame_done;
    logic       err_tmo;
    logic [6:0] pos_cnt;
    logic [9:0] out_cnt;

    // Environment side: issues commands, reports readiness and consumption.
    modport master (
        output frame_go, abort, src_rdy, bsy_in, out_ack,
        input  src_go, strt, tx_done, frame_active, frame_done, err_tmo,
               pos_cnt, out_cnt
    );

    // Controller side.
    modport slave (
        input  frame_go, abort, src_rdy, bsy_in, out_ack,
        output src_go, strt, tx_done, frame_active, frame_done, err_tmo,
               pos_cnt, out_cnt
    );
endinterface

// File: rtl/l2_frame_ctrl.sv
// ---------------------------------------------------------------------------
// l2_frame_ctrl
//
// Purpose:
//   Frame sequencer for the layer-2 convolution datapath. After a frame_go
//   command it issues one strt/src_go pulse per output position whenever the
//   upstream source has a burst ready and the layer is idle. It counts the
//   output words drained downstream. When every position is issued and every
//   word is consumed, it pulses tx_done to rewind the layer for the next
//   image. It also recovers from an abort request or from a stalled drain.
//
// Parameters:
//   N_POS  output positions per frame (1..127)
//   N_OUT  output words downstream must consume per frame (1..1023)
//   TMO    idle cycles tolerated in DRAIN before timing out (1..65535)
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset, shared with the layer
//   bus    handshake/status bundle (see l2_frame_ctrl_if)
// ---------------------------------------------------------------------------
module l2_frame_ctrl #(
    parameter int N_POS = 98,
    parameter int N_OUT = 392,
    parameter int TMO   = 4095
) (
    input  logic           clk,
    input  logic           rst_n,
    l2_frame_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        GAP   = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4,
        FIN   = 3'd5
    } state_t;

    localparam logic [6:0]  POS_LAST = 7'(N_POS);
    localparam logic [9:0]  OUT_LAST = 10'(N_OUT);
    localparam logic [9:0]  OUT_SAT  = 10'h3FF;
    localparam logic [16:0] TMO_LIM  = 17'(TMO);

    state_t      state;
    state_t      state_nxt;

    logic        go_ok;
    logic        issue;
    logic        tmo_hit;
    logic        drain_ok;

    logic [6:0]  pos_cnt_q;
    logic [9:0]  out_cnt_q;
    logic [15:0] idle_cnt;
    logic        err_tmo_q;
    logic        strt_q;
    logic        tx_done_q;
    logic        frame_done_q;

    // The idle counter would reach TMO on this edge if no word is consumed,
    // so the timeout fires exactly TMO idle cycles after the last ack.
    logic        idle_expire;
    assign idle_expire = !bus.out_ack && (({1'b0, idle_cnt} + 17'd1) == TMO_LIM);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the single-cycle decision strobes. Abort wins
    // over timeout, and timeout wins over the normal transition. FIN is not
    // re-entered by abort, so that a held abort cannot trap the FSM there.
    always_comb begin
        state_nxt = state;
        go_ok     = 1'b0;
        issue     = 1'b0;
        tmo_hit   = 1'b0;
        drain_ok  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.frame_go) begin
                    go_ok     = 1'b1;
                    state_nxt = ISSUE;
                end
            end

            ISSUE: begin
                if (bus.abort) begin
                    state_nxt = FIN;
                end else if (bus.src_rdy && !bus.bsy_in) begin
                    issue     = 1'b1;
                    state_nxt = GAP;
                end
            end

            // The layer's busy flag only rises one cycle after strt, so
            // bsy_in is not trusted here.
            GAP: begin
                if (bus.abort) begin
                    state_nxt = FIN;
                end else begin
                    state_nxt = WAIT;
                end
            end

            WAIT: begin
                if (bus.abort) begin
                    state_nxt = FIN;
                end else if (!bus.bsy_in) begin
                    if (pos_cnt_q < POS_LAST) begin
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end
            end

            // The completion test uses the registered count. An ack landing
            // in the same cycle is still counted, but it only takes effect on
            // the following cycle. The >= comparison tolerates words that
            // were over-acknowledged during issue.
            DRAIN: begin
                if (bus.abort) begin
                    state_nxt = FIN;
                end else if (idle_expire) begin
                    tmo_hit   = 1'b1;
                    state_nxt = FIN;
                end else if (out_cnt_q >= OUT_LAST) begin
                    drain_ok  = 1'b1;
                    state_nxt = FIN;
                end
            end

            FIN: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Frame counters and error flag. An accepted frame_go clears everything
    // from the previous frame. An abort leaves the counts and err_tmo alone,
    // so software can still inspect how far the frame progressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_cnt_q <= 7'd0;
            out_cnt_q <= 10'd0;
            err_tmo_q <= 1'b0;
        end else if (go_ok) begin
            pos_cnt_q <= 7'd0;
            out_cnt_q <= 10'd0;
            err_tmo_q <= 1'b0;
        end else begin
            if (issue) begin
                pos_cnt_q <= pos_cnt_q + 7'd1;
            end
            if ((state != IDLE) && bus.out_ack && (out_cnt_q != OUT_SAT)) begin
                out_cnt_q <= out_cnt_q + 10'd1;
            end
            if (tmo_hit) begin
                err_tmo_q <= 1'b1;
            end
        end
    end

    // Drain idle counter. It only runs in DRAIN and restarts on every
    // consumed word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= 16'd0;
        end else if ((state != DRAIN) || bus.out_ack) begin
            idle_cnt <= 16'd0;
        end else begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end

    // Registered pulse outputs. strt/src_go come from the ISSUE decision.
    // tx_done and frame_done line up with the single FIN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strt_q       <= 1'b0;
            tx_done_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            strt_q       <= issue;
            tx_done_q    <= (state_nxt == FIN);
            frame_done_q <= drain_ok && !err_tmo_q;
        end
    end

    assign bus.strt         = strt_q;
    assign bus.src_go       = strt_q;
    assign bus.tx_done      = tx_done_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.frame_active = (state != IDLE);
    assign bus.err_tmo      = err_tmo_q;
    assign bus.pos_cnt      = pos_cnt_q;
    assign bus.out_cnt      = out_cnt_q;

endmodule

// File: tb/tb_l2_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_l2_frame_ctrl
//
// Purpose:
//   Self-checking bench for l2_frame_ctrl with a small frame (3 positions,
//   12 output words, 50-cycle drain timeout) and a behavioural layer model
//   that stays busy for 10 cycles after each strt. The expected position
//   number of each strt is queued when a frame is started and is popped
//   when the strt appears.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_l2_frame_ctrl;

    localparam int N_POS    = 3;
    localparam int N_OUT    = 12;
    localparam int TMO      = 50;
    localparam int BUSY_LEN = 10;
    // strt is registered one edge after the ISSUE decision. The layer's
    // busy rises the cycle after strt and lasts BUSY_LEN cycles. WAIT sees
    // idle one edge later, and ISSUE decides on the next edge.
    localparam int STRT_SPACING = BUSY_LEN + 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int exp_pos[$];
    int busy_cnt     = 0;

    l2_frame_ctrl_if bus();

    l2_frame_ctrl #(
        .N_POS(N_POS),
        .N_OUT(N_OUT),
        .TMO  (TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Layer model: busy for BUSY_LEN cycles after capturing strt. It is
    // rewound by tx_done and shares the reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_cnt <= 0;
        else if (bus.tx_done) busy_cnt <= 0;
        else if (bus.strt) busy_cnt <= BUSY_LEN;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus.bsy_in = (busy_cnt != 0);

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pulse_go();
        @(negedge clk);
        bus.frame_go = 1'b1;
        @(negedge clk);
        bus.frame_go = 1'b0;
    endtask

    task automatic test_reset();
        logic [23:0] obs;
        rst_n = 1'b0;
        bus.frame_go = 1'b0; bus.abort = 1'b0; bus.src_rdy = 1'b0; bus.out_ack = 1'b0;
        repeat (3) @(negedge clk);
        obs = {bus.src_go, bus.strt, bus.tx_done, bus.frame_active, bus.frame_done,
               bus.err_tmo, bus.pos_cnt, bus.out_cnt};
        tests_run++;
        if (obs !== 24'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_held: got %h expected 0", obs);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        obs = {bus.src_go, bus.strt, bus.tx_done, bus.frame_active, bus.frame_done,
               bus.err_tmo, bus.pos_cnt, bus.out_cnt};
        tests_run++;
        if (obs !== 24'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_released: got %h expected 0", obs);
        end
    endtask

    task automatic test_nominal();
        int  n_strt = 0, last_strt = 0, go_cyc = 0, acks_left = N_OUT, want = 0;
        bit  done = 1'b0;
        exp_pos.delete();
        for (int i = 1; i <= N_POS; i++) exp_pos.push_back(i);
        bus.src_rdy = 1'b1;
        pulse_go();
        go_cyc = cyc;
        tests_run++;
        if (bus.frame_active !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL nom_active: got %b expected 1", bus.frame_active);
        end
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (bus.strt === 1'b1) begin
                n_strt++;
                want = (exp_pos.size() > 0) ? exp_pos.pop_front() : -1;
                tests_run++;
                if (bus.pos_cnt !== 7'(want) || bus.src_go !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL nom_strt_pos: got pos %0d src_go %b expected pos %0d src_go 1",
                             bus.pos_cnt, bus.src_go, want);
                end
                tests_run++;
                if (n_strt == 1 && cyc - go_cyc != 1) begin
                    tests_failed++;
                    $display("[TB] FAIL nom_first_latency: got %0d expected 1", cyc - go_cyc);
                end else if (n_strt > 1 && cyc - last_strt != STRT_SPACING) begin
                    tests_failed++;
                    $display("[TB] FAIL nom_spacing: got %0d expected %0d", cyc - last_strt, STRT_SPACING);
                end
                last_strt = cyc;
            end
            if (bus.tx_done === 1'b1) begin
                done = 1'b1;
                tests_run++;
                if (bus.frame_done !== 1'b1 || bus.pos_cnt !== 7'(N_POS) || bus.out_cnt !== 10'(N_OUT)) begin
                    tests_failed++;
                    $display("[TB] FAIL nom_finish: got done %b pos %0d out %0d expected 1 %0d %0d",
                             bus.frame_done, bus.pos_cnt, bus.out_cnt, N_POS, N_OUT);
                end
            end
            bus.out_ack = (n_strt > 0 && acks_left > 0);
            if (bus.out_ack) acks_left--;
        end
        bus.out_ack = 1'b0;
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("[TB] FAIL nom_tx_done: got none expected pulse within 200 cycles");
        end
        @(negedge clk);
        tests_run++;
        if (bus.frame_active !== 1'b0 || bus.tx_done !== 1'b0 || n_strt != N_POS || exp_pos.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL nom_after: got active %b tx %b strts %0d expected 0 0 %0d",
                     bus.frame_active, bus.tx_done, n_strt, N_POS);
        end
    endtask

    task automatic test_backpressure();
        int  n_strt = 0, last_strt = 0, raise_cyc = 0, low_until = 0, acks_left = N_OUT, want = 0;
        bit  done = 1'b0;
        exp_pos.delete();
        for (int i = 1; i <= N_POS; i++) exp_pos.push_back(i);
        bus.src_rdy = 1'b1;
        pulse_go();
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (bus.strt === 1'b1) begin
                n_strt++;
                want = (exp_pos.size() > 0) ? exp_pos.pop_front() : -1;
                tests_run++;
                if (bus.pos_cnt !== 7'(want)) begin
                    tests_failed++;
                    $display("[TB] FAIL bp_strt_pos: got %0d expected %0d", bus.pos_cnt, want);
                end
                if (n_strt == 2) begin
                    tests_run++;
                    if (raise_cyc == 0 || cyc - raise_cyc != 1) begin
                        tests_failed++;
                        $display("[TB] FAIL bp_release: got %0d expected 1 cycle after src_rdy",
                                 cyc - raise_cyc);
                    end
                end
                if (n_strt == 3) begin
                    tests_run++;
                    if (cyc - last_strt != STRT_SPACING) begin
                        tests_failed++;
                        $display("[TB] FAIL bp_spacing: got %0d expected %0d", cyc - last_strt, STRT_SPACING);
                    end
                end
                last_strt = cyc;
                if (n_strt == 1) begin
                    bus.src_rdy = 1'b0;
                    low_until = cyc + 32;
                end
            end
            if (bus.tx_done === 1'b1) begin
                done = 1'b1;
                tests_run++;
                if (bus.frame_done !== 1'b1 || bus.pos_cnt !== 7'(N_POS)) begin
                    tests_failed++;
                    $display("[TB] FAIL bp_finish: got done %b pos %0d expected 1 %0d",
                             bus.frame_done, bus.pos_cnt, N_POS);
                end
            end
            if (!bus.src_rdy && n_strt == 1 && cyc >= low_until) begin
                bus.src_rdy = 1'b1;
                raise_cyc = cyc;
            end
            bus.out_ack = (n_strt > 0 && acks_left > 0);
            if (bus.out_ack) acks_left--;
        end
        bus.out_ack = 1'b0;
        bus.src_rdy = 1'b1;
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("[TB] FAIL bp_tx_done: got none expected pulse within 300 cycles");
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n_strt = 0, last_ack = 0, waited = 0;
        bit seen = 1'b0;
        bus.src_rdy = 1'b1;
        pulse_go();
        for (int k = 0; k < 100 && n_strt < N_POS; k++) begin
            @(negedge clk);
            if (bus.strt === 1'b1) n_strt++;
        end
        repeat (15) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.out_ack = 1'b1;
            last_ack = cyc;
            @(negedge clk);
        end
        bus.out_ack = 1'b0;
        while (!seen && waited < 200) begin
            if (bus.err_tmo === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                waited++;
            end
        end
        tests_run++;
        if (!seen || cyc - (last_ack + 1) != TMO) begin
            tests_failed++;
            $display("[TB] FAIL tmo_delay: got seen %b after %0d cycles expected %0d",
                     seen, cyc - (last_ack + 1), TMO);
        end
        tests_run++;
        if (bus.tx_done !== 1'b1 || bus.frame_done !== 1'b0 || bus.out_cnt !== 10'd8) begin
            tests_failed++;
            $display("[TB] FAIL tmo_fin: got tx %b done %b out %0d expected 1 0 8",
                     bus.tx_done, bus.frame_done, bus.out_cnt);
        end
        @(negedge clk);
        tests_run++;
        if (bus.err_tmo !== 1'b1 || bus.frame_active !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL tmo_sticky: got err %b active %b expected 1 0", bus.err_tmo, bus.frame_active);
        end
        pulse_go();
        tests_run++;
        if (bus.err_tmo !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL tmo_clear: got %b expected 0", bus.err_tmo);
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        tests_run++;
        if (bus.tx_done !== 1'b1 || bus.frame_done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL tmo_abort_cleanup: got tx %b done %b expected 1 0", bus.tx_done, bus.frame_done);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int n_strt = 0, ab_cyc = 0, tx_cyc = 0, late_strt = 0, want = 0;
        exp_pos.delete();
        exp_pos.push_back(1);
        exp_pos.push_back(2);
        bus.src_rdy = 1'b1;
        pulse_go();
        for (int k = 0; k < 100 && n_strt < 2; k++) begin
            @(negedge clk);
            if (bus.strt === 1'b1) begin
                n_strt++;
                want = (exp_pos.size() > 0) ? exp_pos.pop_front() : -1;
                tests_run++;
                if (bus.pos_cnt !== 7'(want)) begin
                    tests_failed++;
                    $display("[TB] FAIL abort_strt_pos: got %0d expected %0d", bus.pos_cnt, want);
                end
            end
        end
        repeat (3) @(negedge clk);
        bus.abort = 1'b1;
        ab_cyc = cyc;
        for (int k = 0; k < 3 && tx_cyc == 0; k++) begin
            @(negedge clk);
            bus.abort = 1'b0;
            if (bus.tx_done === 1'b1) begin
                tx_cyc = cyc;
                tests_run++;
                if (bus.frame_done !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL abort_frame_done: got %b expected 0", bus.frame_done);
                end
            end
        end
        bus.abort = 1'b0;
        tests_run++;
        if (tx_cyc == 0 || tx_cyc - ab_cyc > 2) begin
            tests_failed++;
            $display("[TB] FAIL abort_tx_latency: got %0d expected <= 2", tx_cyc - ab_cyc);
        end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.strt === 1'b1) late_strt++;
        end
        tests_run++;
        if (late_strt != 0 || bus.pos_cnt !== 7'd2 || bus.frame_active !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_hold: got strts %0d pos %0d active %b expected 0 2 0",
                     late_strt, bus.pos_cnt, bus.frame_active);
        end
    endtask

    task automatic test_ignored_inputs();
        int  n_strt = 0;
        bit  done = 1'b0;
        bus.src_rdy = 1'b1;
        pulse_go();
        for (int k = 0; k < 100 && n_strt < N_POS; k++) begin
            @(negedge clk);
            if (bus.strt === 1'b1) n_strt++;
        end
        repeat (15) @(negedge clk);
        pulse_go();
        @(negedge clk);
        tests_run++;
        if (bus.pos_cnt !== 7'(N_POS) || bus.out_cnt !== 10'd0 || bus.frame_active !== 1'b1 || bus.strt !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ign_go_in_drain: got pos %0d out %0d active %b strt %b expected %0d 0 1 0",
                     bus.pos_cnt, bus.out_cnt, bus.frame_active, bus.strt, N_POS);
        end
        for (int i = 0; i < N_OUT; i++) begin
            bus.out_ack = 1'b1;
            @(negedge clk);
        end
        bus.out_ack = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            if (bus.tx_done === 1'b1) begin
                done = 1'b1;
                tests_run++;
                if (bus.frame_done !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL ign_frame_done: got %b expected 1", bus.frame_done);
                end
            end
            @(negedge clk);
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("[TB] FAIL ign_tx_done: got none expected pulse");
        end
        for (int i = 0; i < 5; i++) begin
            bus.out_ack = 1'b1;
            @(negedge clk);
        end
        bus.out_ack = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.out_cnt !== 10'(N_OUT) || bus.frame_active !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ign_ack_in_idle: got out %0d active %b expected %0d 0",
                     bus.out_cnt, bus.frame_active, N_OUT);
        end
        pulse_go();
        tests_run++;
        if (bus.pos_cnt !== 7'd0 || bus.out_cnt !== 10'd0 || bus.frame_active !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ign_restart: got pos %0d out %0d active %b expected 0 0 1",
                     bus.pos_cnt, bus.out_cnt, bus.frame_active);
        end
        bus.abort = 1'b1;
        repeat (2) @(negedge clk);
        bus.abort = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_in_gap();
        logic [23:0] obs;
        int  n_strt = 0, acks_left = N_OUT;
        bit  seen = 1'b0, done = 1'b0;
        bus.src_rdy = 1'b1;
        pulse_go();
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.strt === 1'b1) seen = 1'b1;
        end
        rst_n = 1'b0;
        #1;
        obs = {bus.src_go, bus.strt, bus.tx_done, bus.frame_active, bus.frame_done,
               bus.err_tmo, bus.pos_cnt, bus.out_cnt};
        tests_run++;
        if (!seen || obs !== 24'd0) begin
            tests_failed++;
            $display("[TB] FAIL rst_gap: got seen %b outputs %h expected 1 0", seen, obs);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_go();
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (bus.strt === 1'b1) n_strt++;
            if (bus.tx_done === 1'b1) begin
                done = 1'b1;
                tests_run++;
                if (bus.frame_done !== 1'b1 || bus.pos_cnt !== 7'(N_POS) || bus.out_cnt !== 10'(N_OUT)
                    || n_strt != N_POS) begin
                    tests_failed++;
                    $display("[TB] FAIL rst_rerun: got done %b pos %0d out %0d strts %0d expected 1 %0d %0d %0d",
                             bus.frame_done, bus.pos_cnt, bus.out_cnt, n_strt, N_POS, N_OUT, N_POS);
                end
            end
            bus.out_ack = (n_strt > 0 && acks_left > 0);
            if (bus.out_ack) acks_left--;
        end
        bus.out_ack = 1'b0;
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("[TB] FAIL rst_rerun_tx_done: got none expected pulse");
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_timeout();
        test_abort();
        test_ignored_inputs();
        test_reset_in_gap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
